csa_accum_ctrl: RTL and testbench

Sequential multi-operand accumulator controller built around one generic_csa instance (DW bits). Operands stream in over a valid/ready interface. Each accepted operand is compressed into a registered sum/carry pair in carry-save form, one operand per cycle, with no carry propagation. On the last operand the block resolves the pair with a single carry-propagate add and presents the modulo-2^DW total on a valid/ready output. It serves as the reduction sequencer for dot-product and checksum paths.

---
 rtl/csa_accum_ctrl.sv | 156 +++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
`timescale 1ns/1ps
// csa_accum_ctrl: streams operands into a carry-save sum/carry pair, then resolves the
// pair with one carry-propagate add and hands the modulo-2^DW total downstream.

// 3:2 compressor: out1 is the bitwise sum, out2 the majority shifted up one place.
// The MSB carry is dropped, so the pair stays modulo-2^W exact.
module generic_csa #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  output logic [W-1:0] o_out1,
  output logic [W-1:0] o_out2
);

  logic [W-1:0] w_maj;

  // Bitwise sum and majority of the three inputs
  always_comb begin
    w_maj  = (i_in1 & i_in2) | (i_in1 & i_in3) | (i_in2 & i_in3);
    o_out1 = i_in1 ^ i_in2 ^ i_in3;
    o_out2 = {w_maj[W-2:0], 1'b0};
  end

endmodule

module csa_accum_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_sat
);

  typedef enum logic [1:0] {
    StAccum,
    StResolve,
    StOutput
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [DW-1:0] r_sum;
  logic [DW-1:0] r_carry;
  logic [CW-1:0] r_count;
  logic          r_sat;
  logic [DW-1:0] r_out_data;
  logic [CW-1:0] r_out_count;
  logic          r_out_sat;

  logic [DW-1:0] w_csa_sum;
  logic [DW-1:0] w_csa_carry;
  logic          w_xfer;
  logic          w_count_max;

  generic_csa #(
    .W (DW)
  ) u_csa (
    .i_in1  (r_sum),
    .i_in2  (r_carry),
    .i_in3  (in_data),
    .o_out1 (w_csa_sum),
    .o_out2 (w_csa_carry)
  );

  assign w_xfer      = in_valid & in_ready;
  assign w_count_max = &r_count;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StAccum;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: accumulate until the last operand, one resolve cycle, then hold for downstream
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StAccum:   if (w_xfer && in_last) w_state_next = StResolve;
      StResolve: w_state_next = StOutput;
      StOutput:  if (out_ready) w_state_next = StAccum;
      default:   w_state_next = StAccum;
    endcase
  end

  // Handshake outputs depend on state only, so no in_* -> out_* or out_ready -> in_ready path
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StAccum:   in_ready  = 1'b1;
      StResolve: ;
      StOutput:  out_valid = 1'b1;
      default:   ;
    endcase
  end

  // Carry-save accumulation, resolve add and group clear on result handoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      unique case (r_state)
        StAccum: begin
          if (w_xfer) begin
            r_sum   <= w_csa_sum;
            r_carry <= w_csa_carry;
            if (w_count_max) begin
              r_sat <= 1'b1;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        StResolve: begin
          r_out_data  <= r_sum + r_carry;
          r_out_count <= r_count;
          r_out_sat   <= r_sat;
        end
        StOutput: begin
          if (out_ready) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for csa_accum_ctrl: directed corner cases plus randomized groups.
module tb_csa_accum_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        out_sat;

  // Second instance with a 2-bit counter for saturation
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data = '0;
  logic        s_in_last = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_count;
  logic        s_out_sat;

  logic        dir_ready = 1'b1;
  logic        rand_ready = 1'b0;
  logic        r_rand_rdy = 1'b1;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;

  exp_t        sb_q[$];
  logic [31:0] m_sum = '0;
  int          m_cnt = 0;

  assign out_ready = rand_ready ? r_rand_rdy : dir_ready;

  csa_accum_ctrl #(.DW(32), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  csa_accum_ctrl #(.DW(32), .CW(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_count (s_out_count),
    .out_sat   (s_out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every delivered result against the oldest expected group
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h expected=none", out_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        popped++;
        chk("sb_data", 64'(out_data), 64'(e.data));
        chk("sb_count", 64'(out_count), 64'(e.cnt));
        chk("sb_sat", 64'(out_sat), 64'(e.sat));
      end
    end
  end

  // Random downstream backpressure, changed away from the active edge
  always @(posedge clk) begin
    #1;
    r_rand_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic model_clear();
    m_sum = '0;
    m_cnt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input int max_idle);
    int   n;
    int   t;
    logic rdy;
    n = (max_idle > 0) ? int'($urandom_range(0, max_idle)) : 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 32'hxxxx_xxxx;
      in_last  = $urandom_range(0, 1) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        chk("in_ready_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_sum += d;
    m_cnt++;
    if (last) begin
      exp_t e;
      e.data = m_sum;
      e.cnt  = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
      e.sat  = (m_cnt > 255);
      sb_q.push_back(e);
      pushed++;
      model_clear();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int i;
    i = 0;
    while (!out_valid && i < max_cyc) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("wait_out_valid", 64'(out_valid), 64'(1));
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_sat", 64'(out_sat), 64'(0));
    idle(2);
    rst = 1'b0;
    idle(1);

    // Basic sum with latency check
    send(32'd5, 1'b0, 0);
    send(32'd7, 1'b0, 0);
    send(32'd9, 1'b1, 0);
    chk("lat_resolve_valid", 64'(out_valid), 64'(0));
    chk("lat_resolve_ready", 64'(in_ready), 64'(0));
    idle(1);
    chk("lat_output_valid", 64'(out_valid), 64'(1));
    chk("basic_data", 64'(out_data), 64'(21));
    idle(1);
    chk("basic_ready_back", 64'(in_ready), 64'(1));

    // Wrap
    send(32'hFFFF_FFFF, 1'b0, 0);
    send(32'h0000_0002, 1'b1, 0);
    wait_valid(10);
    idle(2);

    // Stalled input then output backpressure
    dir_ready = 1'b0;
    send(32'd1, 1'b0, 0);
    idle(1);
    send(32'd2, 1'b0, 0);
    idle(1);
    send(32'd3, 1'b1, 0);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_data", 64'(out_data), 64'(6));
      chk("bp_count", 64'(out_count), 64'(3));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      idle(1);
    end
    dir_ready = 1'b1;
    idle(1);
    chk("release_in_ready", 64'(in_ready), 64'(1));
    chk("release_out_valid", 64'(out_valid), 64'(0));

    // Single operand
    send(32'hA5A5_A5A5, 1'b1, 0);
    wait_valid(10);
    idle(2);

    // Saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 32'd1;
      s_in_last  = (i == 4);
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    for (int i = 0; i < 10 && !s_out_valid; i++) idle(1);
    chk("sat_valid", 64'(s_out_valid), 64'(1));
    chk("sat_data", 64'(s_out_data), 64'(5));
    chk("sat_count", 64'(s_out_count), 64'(3));
    chk("sat_flag", 64'(s_out_sat), 64'(1));
    idle(2);

    // Reset mid-group discards the partial sum
    send(32'd10, 1'b0, 0);
    send(32'd20, 1'b0, 0);
    rst = 1'b1;
    model_clear();
    idle(1);
    rst = 1'b0;
    send(32'd3, 1'b1, 0);
    wait_valid(10);
    idle(2);

    // Reset while a result is waiting drops out_valid immediately
    dir_ready = 1'b0;
    send(32'd7, 1'b1, 0);
    wait_valid(10);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_output_valid", 64'(out_valid), 64'(0));
    chk("rst_output_in_ready", 64'(in_ready), 64'(1));
    chk("rst_output_data", 64'(out_data), 64'(0));
    void'(sb_q.pop_back());
    pushed--;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    dir_ready = 1'b1;
    idle(1);

    // Randomized groups with input stalls and output backpressure
    rand_ready = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) send($urandom, k == n - 1, 1);
    end
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) idle(1);
    rand_ready = 1'b0;
    idle(2);

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("sb_popped", 64'(popped), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
